// File: rtl/poly_pkg.sv
// Shared types and sizing helpers for the iterative polynomial multiplier.
package poly_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DEF_N = 8;
   localparam int DEF_W = 8;
   localparam int CNT_W = $clog2(DEF_N);

   typedef logic [DEF_W-1:0] coeff_t;

   // Counter width for an N-coefficient job; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/poly_mac_lane.sv
// One coefficient lane: acc_out = acc_in + a*b, wrapping mod 2^W.
module poly_mac_lane #(
   parameter int W = 8
) (
   input  logic [W-1:0] acc_in,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] acc_out
);

   assign acc_out = acc_in + a * b;

endmodule

// File: rtl/poly_mul_engine.sv
// Iterative multiplier over Z_(2^W)[x]/(x^N -/+ 1): one a-coefficient per
// cycle is broadcast against a rotating copy of b into N parallel MAC lanes.
module poly_mul_engine
   import poly_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                negacyclic,
   input  logic                accumulate,
   input  logic [N-1:0][W-1:0] as,
   input  logic [N-1:0][W-1:0] bs,
   output logic                busy,
   output logic [N-1:0][W-1:0] cs,
   output logic                done
);

   localparam int CW = cnt_width(N);

   state_t              state_reg;
   logic [CW-1:0]       cnt_reg;
   logic                neg_reg;
   logic                busy_reg;
   logic                done_reg;
   logic [N-1:0][W-1:0] a_reg;
   logic [N-1:0][W-1:0] bsh_reg;
   logic [N-1:0][W-1:0] acc_reg;
   logic [N-1:0][W-1:0] cs_reg;
   logic [N-1:0][W-1:0] acc_next;
   logic [N-1:0][W-1:0] bsh_rot;
   logic [W-1:0]        a_sel;

   assign a_sel = a_reg[cnt_reg];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         poly_mac_lane #(.W(W)) u_lane (
            .acc_in  (acc_reg[gi]),
            .a       (a_sel),
            .b       (bsh_reg[gi]),
            .acc_out (acc_next[gi])
         );
         // The coefficient wrapping past x^N re-enters at x^0, negated
         // when reducing modulo x^N+1.
         if (gi == 0) begin : g_wrap
            assign bsh_rot[0] = neg_reg ? -bsh_reg[N-1] : bsh_reg[N-1];
         end else begin : g_shift
            assign bsh_rot[gi] = bsh_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         neg_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         a_reg     <= '0;
         bsh_reg   <= '0;
         acc_reg   <= '0;
         cs_reg    <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= as;
                  bsh_reg   <= bs;
                  neg_reg   <= negacyclic;
                  acc_reg   <= accumulate ? cs_reg : '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               acc_reg <= acc_next;
               bsh_reg <= bsh_rot;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CW'(N - 1)) begin
                  cs_reg    <= acc_next;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign cs   = cs_reg;

endmodule

// File: tb/tb_poly_mul_engine.sv
// Randomised scoreboard bench: driver queues reference products, a monitor
// compares them against cs on every done pulse.
module tb_poly_mul_engine;

   localparam int N = 8;
   localparam int W = 8;

   typedef logic [N-1:0][W-1:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic negacyclic = 1'b0;
   logic accumulate = 1'b0;
   vec_t as_i = '0;
   vec_t bs_i = '0;
   logic busy;
   vec_t cs;
   logic done;

   int   tests = 0;
   int   fails = 0;
   int   job_no = 0;
   vec_t model_cs = '0;
   vec_t exp_q[$];
   logic prev_done = 1'b0;

   poly_mul_engine #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .negacyclic (negacyclic),
      .accumulate (accumulate),
      .as         (as_i),
      .bs         (bs_i),
      .busy       (busy),
      .cs         (cs),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Schoolbook product: term x^(i+j) folds back to x^(i+j-N), with sign
   // flipped when the ring is negacyclic.
   function automatic vec_t ref_mul(input vec_t a, input vec_t b,
                                    input bit neg, input vec_t base);
      vec_t r;
      r = base;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            int unsigned prod;
            int          k;
            logic [W-1:0] p;
            prod = int'(a[i]) * int'(b[j]);
            p = prod[W-1:0];
            k = i + j;
            if (k >= N) begin
               k = k - N;
               if (neg) p = -p;
            end
            r[k] = r[k] + p;
         end
      end
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int k = 0; k < N; k++) v[k] = W'($urandom);
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the oldest expected product on every done pulse.
   always @(negedge clk) begin
      if (done) begin
         vec_t e;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: got cs=%h expected no done", cs);
         end else begin
            e = exp_q.pop_front();
            job_no++;
            if (cs !== e) begin
               fails++;
               $display("FAIL result job %0d: got %h expected %h", job_no, cs, e);
            end else begin
               $display("[TB] job %0d cs=%h ok", job_no, cs);
            end
         end
         check("busy_at_done", 64'(busy), 64'd1);
         if (prev_done) begin
            tests++;
            fails++;
            $display("FAIL done_width: got 2+ cycles expected 1");
         end
      end
      prev_done <= done;
   end

   task automatic do_job(input vec_t a, input vec_t b, input bit neg,
                         input bit accm, input bit poke);
      vec_t e;
      int   lat;
      @(negedge clk);
      as_i = a;
      bs_i = b;
      negacyclic = neg;
      accumulate = accm;
      start = 1'b1;
      e = ref_mul(a, b, neg, accm ? model_cs : vec_t'('0));
      model_cs = e;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      as_i = rand_vec();
      bs_i = rand_vec();
      lat = 1;
      while (!done && lat <= 40) begin
         if (poke && lat == 3) begin
            start = 1'b1;
            negacyclic = ~neg;
            accumulate = ~accm;
         end
         if (poke && lat == 4) start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("latency", 64'(lat), 64'(N + 1));
      @(negedge clk);
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_after_done", 64'(done), 64'd0);
   endtask

   initial begin
      vec_t a, b, e;
      int   lat;

      repeat (3) @(negedge clk);
      check("reset_cs", 64'(cs), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // a = 1, b = 1..8
      a = '0; a[0] = 8'd1;
      for (int k = 0; k < N; k++) b[k] = W'(k + 1);
      do_job(a, b, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) check("identity", 64'(cs[k]), 64'(k + 1));

      // x * x^7 wraps to -1 or +1
      a = '0; a[1] = 8'd1;
      b = '0; b[7] = 8'd1;
      do_job(a, b, 1'b1, 1'b0, 1'b0);
      e = '0; e[0] = 8'hFF;
      check("x8_nega", 64'(cs), 64'(e));
      do_job(a, b, 1'b0, 1'b0, 1'b0);
      e = '0; e[0] = 8'h01;
      check("x8_cyclic", 64'(cs), 64'(e));

      // coefficient wrap
      a = '0; a[0] = 8'd16;
      b = '0; b[0] = 8'd16;
      do_job(a, b, 1'b0, 1'b0, 1'b0);
      check("wrap16", 64'(cs[0]), 64'h00);
      a[0] = 8'hFF; b[0] = 8'hFF;
      do_job(a, b, 1'b0, 1'b0, 1'b0);
      check("wrapFF", 64'(cs[0]), 64'h01);

      // accumulate, with a start pulse during RUN
      a = '0; a[0] = 8'd2;
      b = '0; b[0] = 8'd3;
      do_job(a, b, 1'b0, 1'b0, 1'b0);
      check("acc_first", 64'(cs[0]), 64'd6);
      a[0] = 8'd1; b[0] = 8'd4;
      do_job(a, b, 1'b0, 1'b1, 1'b1);
      check("acc_second", 64'(cs[0]), 64'd10);

      // all ones
      a = '1; b = '1;
      do_job(a, b, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) check("ones_cyclic", 64'(cs[k]), 64'd8);
      do_job(a, b, 1'b1, 1'b0, 1'b0);
      check("ones_nega0", 64'(cs[0]), 64'hFA);
      check("ones_nega3", 64'(cs[3]), 64'h00);
      check("ones_nega7", 64'(cs[7]), 64'h08);

      // asynchronous reset mid-run at cnt = 4
      @(negedge clk);
      as_i = rand_vec();
      bs_i = rand_vec();
      negacyclic = 1'b0;
      accumulate = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (lat < 5) begin
         @(negedge clk);
         lat++;
      end
      check("busy_before_rst", 64'(busy), 64'd1);
      #1 rst = 1'b0;
      #1;
      check("rst_cs", 64'(cs), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      model_cs = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      check("no_resume_busy", 64'(busy), 64'd0);
      a = '0; a[0] = 8'd3;
      b = '0; b[2] = 8'd5;
      do_job(a, b, 1'b0, 1'b1, 1'b0);
      check("after_rst", 64'(cs[2]), 64'd15);

      // randomised jobs, some with ignored mid-run starts
      for (int t = 0; t < 40; t++) begin
         do_job(rand_vec(), rand_vec(), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (4) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
